// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory hierarchy: bus widths and the
// state/client enums of the L2 arbiter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_chunk;
  typedef logic [15:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } l2_arb_state_t;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } l2_arb_client_t;

endpackage

// File: rtl/l2_arbiter_control.sv
// L2 arbiter control: grant FSM, last-grant tracking and tie-break.
// Tie-break is round-robin when L2_ARB_RR_EN is defined, else D has priority.
module l2_arbiter_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic l2_resp,
  output logic grant_i,
  output logic grant_d
);

  l2_arb_state_t  state_q, state_d;
  l2_arb_client_t last_grant_q, last_grant_d;
  l2_arb_client_t tie_winner;

  always_comb begin
`ifdef L2_ARB_RR_EN
    tie_winner = (last_grant_q == CLIENT_I) ? CLIENT_D : CLIENT_I;
`else
    tie_winner = CLIENT_D;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= CLIENT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A grant is only released by l2_resp; a client dropping its request
  // mid-transaction does not abort the L2 access.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = (tie_winner == CLIENT_D) ? GRANT_D : GRANT_I;
        end else if (i_req) begin
          state_d = GRANT_I;
        end else if (d_req) begin
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        grant_i = 1'b1;
        if (l2_resp) begin
          last_grant_d = CLIENT_I;
          state_d      = IDLE;
        end
      end
      GRANT_D: begin
        grant_d = 1'b1;
        if (l2_resp) begin
          last_grant_d = CLIENT_D;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/l2_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of the unified L2.
// Optional round-robin tie-break via L2_ARB_RR_EN (see l2_arbiter_control).
module l2_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,

  input  lc3b_word      i_mem_address,
  input  logic          i_mem_read,
  output lc3b_chunk     i_mem_rdata,
  output logic          i_mem_resp,

  input  lc3b_word      d_mem_address,
  input  lc3b_chunk     d_mem_wdata,
  input  logic          d_mem_read,
  input  logic          d_mem_write,
  input  lc3b_mem_wmask d_mem_byte_enable,
  output lc3b_chunk     d_mem_rdata,
  output logic          d_mem_resp,

  output lc3b_word      l2_address,
  output lc3b_chunk     l2_wdata,
  output logic          l2_read,
  output logic          l2_write,
  output lc3b_mem_wmask l2_byte_enable,
  input  lc3b_chunk     l2_rdata,
  input  logic          l2_resp
);

  logic grant_i;
  logic grant_d;

  l2_arbiter_control u_control (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_mem_read),
    .d_req   (d_mem_read | d_mem_write),
    .l2_resp (l2_resp),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    l2_address     = '0;
    l2_wdata       = '0;
    l2_read        = 1'b0;
    l2_write       = 1'b0;
    l2_byte_enable = '0;
    if (grant_i) begin
      l2_address = i_mem_address;
      l2_read    = i_mem_read;
    end else if (grant_d) begin
      l2_address     = d_mem_address;
      l2_wdata       = d_mem_wdata;
      l2_byte_enable = d_mem_byte_enable;
      l2_write       = d_mem_write;
      // Write wins when the D-cache raises both strobes.
      l2_read        = d_mem_read & ~d_mem_write;
    end
  end

  assign i_mem_rdata = l2_rdata;
  assign d_mem_rdata = l2_rdata;
  assign i_mem_resp  = grant_i & l2_resp;
  assign d_mem_resp  = grant_d & l2_resp;

endmodule
